// File: rtl/masked_pkg.sv
// Shared types for the masked adder datapath: unmasking FSM states and share count.
package masked_pkg;

  localparam int N_SHARES = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    COMBINE = 2'd2,
    HOLD    = 2'd3
  } state_t;

endpackage : masked_pkg

// File: rtl/share_recombine.sv
// Registered XOR of two share vectors; the only point where the share planes meet.
module share_recombine #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] share_a,
  input  logic [W-1:0] share_b,
  output logic [W-1:0] q
);

  logic [W-1:0] q_reg;

  always_ff @(posedge clk) begin
    if (clr) begin
      q_reg <= '0;
    end else if (en) begin
      q_reg <= share_a ^ share_b;
    end
  end

  assign q = q_reg;

endmodule : share_recombine

// File: rtl/masked_share_unmasker.sv
// Bit-serial unmasking end: collects two share planes LSB first, then recombines
// them once in a registered stage and presents the word over valid/ready.
module masked_share_unmasker
  import masked_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_first,
  input  logic             sum0,
  input  logic             sum1,
  input  logic             carry0,
  input  logic             carry1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             overrun,
  output logic             drop
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  state_t           state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] share0_reg;
  logic [WIDTH-1:0] share1_reg;
  logic             cshare0_reg;
  logic             cshare1_reg;
  logic             out_valid_reg;
  logic             overrun_reg;
  logic             drop_reg;
  logic             beat;
  logic [WIDTH:0]   combined;

  assign in_ready = rst_n & ((state_reg == IDLE) | (state_reg == COLLECT));
  assign beat     = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      share0_reg    <= '0;
      share1_reg    <= '0;
      cshare0_reg   <= 1'b0;
      cshare1_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
      overrun_reg   <= 1'b0;
      drop_reg      <= 1'b0;
    end else begin
      overrun_reg <= 1'b0;
      drop_reg    <= 1'b0;
      case (state_reg)
        IDLE, COLLECT: begin
          if (beat) begin
            if (in_first) begin
              // A new word (or a restart) always lands at bit 0.
              share0_reg[0] <= sum0;
              share1_reg[0] <= sum1;
              cnt_reg       <= CW'(1);
              overrun_reg   <= (state_reg == COLLECT);
              if (WIDTH == 1) begin
                cshare0_reg <= carry0;
                cshare1_reg <= carry1;
                state_reg   <= COMBINE;
              end else begin
                state_reg <= COLLECT;
              end
            end else if (state_reg == IDLE) begin
              drop_reg <= 1'b1;
            end else begin
              share0_reg[cnt_reg] <= sum0;
              share1_reg[cnt_reg] <= sum1;
              cnt_reg             <= cnt_reg + 1'b1;
              if (cnt_reg == LAST_IDX) begin
                cshare0_reg <= carry0;
                cshare1_reg <= carry1;
                state_reg   <= COMBINE;
              end
            end
          end
        end
        COMBINE: begin
          // Shares are wiped in the same cycle they are consumed.
          share0_reg    <= '0;
          share1_reg    <= '0;
          cshare0_reg   <= 1'b0;
          cshare1_reg   <= 1'b0;
          cnt_reg       <= '0;
          out_valid_reg <= 1'b1;
          state_reg     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  share_recombine #(
    .W(WIDTH + 1)
  ) u_recombine (
    .clk     (clk),
    .clr     (~rst_n),
    .en      (state_reg == COMBINE),
    .share_a ({cshare0_reg, share0_reg}),
    .share_b ({cshare1_reg, share1_reg}),
    .q       (combined)
  );

  assign out_data  = combined[WIDTH-1:0];
  assign out_carry = combined[WIDTH];
  assign out_valid = out_valid_reg;
  assign overrun   = overrun_reg;
  assign drop      = drop_reg;

endmodule : masked_share_unmasker

// File: tb/tb_masked_share_unmasker.sv
// Randomized self-checking bench: expected words are the XOR of the share words sent.
module tb_masked_share_unmasker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_first, sum0, sum1, carry0, carry1, out_ready;
  logic       in_ready, out_valid, out_carry, overrun, drop;
  logic [7:0] out_data;

  logic       in_valid1, in_first1, sum0_1, sum1_1, carry0_1, carry1_1, out_ready1;
  logic       in_ready1, out_valid1, out_carry1, overrun1, drop1;
  logic [0:0] out_data1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  masked_share_unmasker #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_first(in_first), .sum0(sum0), .sum1(sum1), .carry0(carry0), .carry1(carry1),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_carry(out_carry), .overrun(overrun), .drop(drop)
  );

  masked_share_unmasker #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_first(in_first1), .sum0(sum0_1), .sum1(sum1_1), .carry0(carry0_1), .carry1(carry1_1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .out_carry(out_carry1), .overrun(overrun1), .drop(drop1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one 8-bit word as share planes w0/w1; carries only meaningful on the last beat.
  task automatic send_word(input logic [7:0] w0, input logic [7:0] w1, input logic c0,
                           input logic c1, input bit gaps, input bit exp_ovr);
    for (int i = 0; i < 8; i++) begin
      if (gaps && i > 0) begin
        int g;
        g = $urandom_range(0, 2);
        repeat (g) begin
          in_valid = 1'b0;
          tick();
          checks++;
          if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL gap_in_ready got %b exp 1", in_ready);
          end
        end
      end
      in_valid = 1'b1;
      in_first = (i == 0);
      sum0     = w0[i];
      sum1     = w1[i];
      carry0   = (i == 7) ? c0 : 1'($urandom);
      carry1   = (i == 7) ? c1 : 1'($urandom);
      tick();
      in_valid = 1'b0;
      in_first = 1'b0;
      checks++;
      if (overrun !== ((i == 0) ? exp_ovr : 1'b0) || drop !== 1'b0) begin
        errors++;
        $display("FAIL beat_pulses beat %0d got overrun=%b drop=%b exp overrun=%b drop=0",
                 i, overrun, drop, (i == 0) ? exp_ovr : 1'b0);
      end
    end
  endtask

  // Called right after the last beat's edge: checks latency, hold stability and return to idle.
  task automatic expect_word(input logic [7:0] exp_d, input logic exp_c, input string name,
                             input int hold_cycles);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_combine got valid=%b ready=%b exp valid=0 ready=0", name, out_valid, in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp_d || out_carry !== exp_c) begin
      errors++;
      $display("FAIL %s_out got valid=%b data=%h carry=%b exp valid=1 data=%h carry=%b",
               name, out_valid, out_data, out_carry, exp_d, exp_c);
    end
    for (int h = 0; h < hold_cycles; h++) begin
      out_ready = 1'b0;
      in_valid  = 1'($urandom);
      in_first  = 1'($urandom);
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_d || in_ready !== 1'b0 || drop !== 1'b0) begin
        errors++;
        $display("FAIL %s_hold got valid=%b data=%h ready=%b drop=%b exp valid=1 data=%h ready=0 drop=0",
                 name, out_valid, out_data, in_ready, drop, exp_d);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_first  = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== exp_d) begin
      errors++;
      $display("FAIL %s_release got valid=%b ready=%b data=%h exp valid=0 ready=1 data=%h",
               name, out_valid, in_ready, out_data, exp_d);
    end
    $display("word %s data=%h carry=%b exp %h/%b", name, out_data, out_carry, exp_d, exp_c);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00 || out_carry !== 1'b0 ||
        overrun !== 1'b0 || drop !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got ready=%b valid=%b data=%h carry=%b ovr=%b drop=%b exp all 0",
               in_ready, out_valid, out_data, out_carry, overrun, drop);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || in_ready1 !== 1'b1) begin
      errors++;
      $display("FAIL reset_release got ready=%b ready1=%b exp 1 1", in_ready, in_ready1);
    end
  endtask

  task automatic test_basic();
    send_word(8'h3C, 8'h99, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_word(8'hA5, 1'b1, "basic", 0);
  endtask

  task automatic test_hold();
    send_word(8'h3C, 8'h99, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_word(8'hA5, 1'b1, "hold", 3);
  endtask

  task automatic test_overrun();
    logic [7:0] w0;
    logic       c0, c1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_first = (i == 0);
      sum0 = 1'b1;
      sum1 = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    w0 = 8'($urandom);
    c0 = 1'($urandom);
    c1 = 1'($urandom);
    send_word(w0, w0 ^ 8'h5A, c0, c1, 1'b0, 1'b1);
    expect_word(8'h5A, c0 ^ c1, "overrun", 1);
  endtask

  task automatic test_drop();
    logic [7:0] w0, w1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_first = 1'b0;
      sum0 = 1'($urandom);
      sum1 = 1'($urandom);
      tick();
      checks++;
      if (drop !== 1'b1 || in_ready !== 1'b1 || overrun !== 1'b0) begin
        errors++;
        $display("FAIL drop_pulse got drop=%b ready=%b ovr=%b exp drop=1 ready=1 ovr=0",
                 drop, in_ready, overrun);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (drop !== 1'b0) begin
      errors++;
      $display("FAIL drop_clear got %b exp 0", drop);
    end
    w0 = 8'($urandom);
    w1 = 8'($urandom);
    send_word(w0, w1, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_word(w0 ^ w1, 1'b1, "after_drop", 0);
  endtask

  task automatic test_reset_midword();
    logic [7:0] w0;
    logic       c;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_first = (i == 0);
      sum0 = 1'($urandom);
      sum1 = 1'($urandom);
      tick();
    end
    in_valid = 1'b0;
    in_first = 1'b0;
    rst_n = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL midreset_low got ready=%b valid=%b data=%h exp 0 0 00", in_ready, out_valid, out_data);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_release got ready=%b valid=%b exp 1 0", in_ready, out_valid);
    end
    w0 = 8'($urandom);
    c  = 1'($urandom);
    send_word(w0, w0 ^ 8'h0F, c, c, 1'b0, 1'b0);
    expect_word(8'h0F, 1'b0, "midreset", 0);
  endtask

  task automatic test_back_to_back();
    logic [7:0] w0, w1;
    logic       c0, c1;
    for (int k = 0; k < 3; k++) begin
      w0 = 8'($urandom);
      w1 = 8'($urandom);
      c0 = 1'($urandom);
      c1 = 1'($urandom);
      send_word(w0, w1, c0, c1, 1'b0, 1'b0);
      expect_word(w0 ^ w1, c0 ^ c1, "b2b", 0);
    end
  endtask

  task automatic test_random();
    logic [7:0] w0, w1;
    logic       c0, c1;
    for (int k = 0; k < 20; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b1;
        in_first = 1'b0;
        tick();
        in_valid = 1'b0;
        checks++;
        if (drop !== 1'b1) begin
          errors++;
          $display("FAIL random_drop got %b exp 1", drop);
        end
      end
      w0 = 8'($urandom);
      w1 = 8'($urandom);
      c0 = 1'($urandom);
      c1 = 1'($urandom);
      send_word(w0, w1, c0, c1, 1'b1, 1'b0);
      expect_word(w0 ^ w1, c0 ^ c1, "random", $urandom_range(0, 3));
    end
  endtask

  task automatic test_width1();
    logic s0, s1, c0, c1;
    for (int k = 0; k < 5; k++) begin
      if (k == 0) begin
        s0 = 1'b1; s1 = 1'b1; c0 = 1'b0; c1 = 1'b1;
      end else begin
        s0 = 1'($urandom); s1 = 1'($urandom); c0 = 1'($urandom); c1 = 1'($urandom);
      end
      in_valid1 = 1'b1;
      in_first1 = 1'b1;
      sum0_1 = s0; sum1_1 = s1; carry0_1 = c0; carry1_1 = c1;
      tick();
      in_valid1 = 1'b0;
      in_first1 = 1'b0;
      checks++;
      if (out_valid1 !== 1'b0 || in_ready1 !== 1'b0) begin
        errors++;
        $display("FAIL w1_combine got valid=%b ready=%b exp 0 0", out_valid1, in_ready1);
      end
      tick();
      checks++;
      if (out_valid1 !== 1'b1 || out_data1 !== (s0 ^ s1) || out_carry1 !== (c0 ^ c1)) begin
        errors++;
        $display("FAIL w1_out got valid=%b data=%b carry=%b exp valid=1 data=%b carry=%b",
                 out_valid1, out_data1, out_carry1, s0 ^ s1, c0 ^ c1);
      end
      out_ready1 = 1'b1;
      tick();
      out_ready1 = 1'b0;
      checks++;
      if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
        errors++;
        $display("FAIL w1_release got valid=%b ready=%b exp 0 1", out_valid1, in_ready1);
      end
      $display("word w1 data=%b carry=%b exp %b/%b", out_data1, out_carry1, s0 ^ s1, c0 ^ c1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_first = 1'b0; sum0 = 1'b0; sum1 = 1'b0;
    carry0 = 1'b0; carry1 = 1'b0; out_ready = 1'b0;
    in_valid1 = 1'b0; in_first1 = 1'b0; sum0_1 = 1'b0; sum1_1 = 1'b0;
    carry0_1 = 1'b0; carry1_1 = 1'b0; out_ready1 = 1'b0;
    test_reset();
    test_basic();
    test_hold();
    test_overrun();
    test_drop();
    test_reset_midword();
    test_back_to_back();
    test_random();
    test_width1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_masked_share_unmasker

// File: doc/masked_share_unmasker.md
# masked_share_unmasker

Bit-serial unmasking end for the two-share Boolean-masked adder datapath. It accepts one bit position per beat, LSB first, from the masked half/full-adder chain: sum shares plus the carry shares of that position. It stores both share planes in separate registers until a full WIDTH-bit word is captured, then recombines them in one registered step. The result is an unmasked sum word and carry-out, delivered over a valid/ready interface. The block sits at the boundary where masked results leave the protected domain.

## Interface
- WIDTH, 8, bits per word (≥1); number of beats per word
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; synchronous, active-low
- in_valid  in  1  beat present
- in_ready  out  1  block accepts beat
- in_first  in  1  beat is bit 0 of a new word
- sum0  in  1  sum share 0 of current bit
- sum1  in  1  sum share 1 of current bit
- carry0  in  1  carry share 0 of current bit (used only on beat WIDTH-1)
- carry1  in  1  carry share 1 of current bit (used only on beat WIDTH-1)
- out_valid  out  1  unmasked word available
- out_ready  in  1  consumer takes word
- out_data  out  WIDTH  unmasked sum, sum0^sum1 per bit
- out_carry  out  1  unmasked carry-out of bit WIDTH-1
- overrun  out  1  one-cycle pulse: word restarted by in_first mid-word
- drop  out  1  one-cycle pulse: beat without in_first discarded in IDLE

## Operation
- Beat accepted = in_valid & in_ready.
- States: IDLE, COLLECT, COMBINE, HOLD.
- IDLE:
  - in_ready=1.
  - Accepted beat with in_first=1: store sum0/sum1 at index 0 of share0/share1 registers, cnt←1, go to COLLECT. If WIDTH==1, also store carry shares and go to COMBINE.
  - Accepted beat with in_first=0: discarded; drop pulses.
- COLLECT:
  - in_ready=1.
  - Accepted beat with in_first=0: store shares at index cnt, cnt←cnt+1. On the beat with cnt==WIDTH-1, also store carry0/carry1 and go to COMBINE.
  - Accepted beat with in_first=1: restart. Store at index 0, cnt←1, overrun pulses. Previously stored share bits are overwritten as beats arrive.
  - in_valid=0: hold state and cnt. No timeout.
- COMBINE:
  - in_ready=0.
  - out_data←share0^share1 and out_carry←cshare0^cshare1, both registered.
  - In the same cycle, all share registers and cnt are cleared to 0 (zeroization). Go to HOLD.
- HOLD:
  - out_valid=1, in_ready=0.
  - out_data and out_carry are stable until out_valid & out_ready; then go to IDLE.
  - out_data retains its last value after the handshake (not cleared).
- Masking rules:
  - Share0 and share1 planes are never combined except in the COMBINE register stage.
  - No output is a combinational function of sum*/carry* ports.
  - Inputs are not XORed before being registered.

## Timing
- Reset (rst_n low at a clock edge): state=IDLE; cnt, share registers, out_data, out_carry all 0; out_valid=0; overrun=0; drop=0.
- in_ready=0 while rst_n is low; in_ready=1 in the first cycle after deassertion.
- Reset mid-word or in HOLD: the word is lost and no output is produced.
- Last beat accepted in cycle t: COMBINE in t+1, out_valid=1 from t+2.
- Minimum word period is WIDTH+2 cycles (word accepted from IDLE, immediate out_ready).
- out_ready is ignored when out_valid=0. Input beats presented in COMBINE/HOLD are not accepted (in_ready=0).
- overrun and drop are registered pulses, high in the cycle after the offending beat.

## Structure
- Shared package masked_pkg: state enum (IDLE, COLLECT, COMBINE, HOLD) and N_SHARES=2 constant.
- Sub-module share_recombine: a WIDTH+1-bit registered XOR of two share vectors, with enable and synchronous clear. It is the only place where shares meet.
- Top level holds the FSM, cnt (width $clog2(WIDTH) min 1), share registers and pulses.

## Test plan
- WIDTH=8, word 0xA5 with share0=0x3C and share1=0x99 sent LSB first, last beat carry0=1, carry1=0 -> out_valid at t+2, out_data=0xA5, out_carry=1. Share registers read 0 in HOLD.
- Same word with out_ready low for 3 cycles in HOLD -> out_valid and out_data=0xA5 stable throughout, in_ready=0. IDLE is entered the cycle after out_ready rises.
- First word: 4 beats of share0=0xFF, share1=0x00, then in_first on beat 5. Continue with 8 beats forming 0x5A -> overrun pulses once, out_data=0x5A.
- In IDLE, in_valid=1 with in_first=0 for 2 beats -> drop pulses twice, no state change. A following valid word decodes correctly.
- rst_n low for 1 cycle after 5 beats, then a full word 0x0F/carry 0 -> no output for the aborted word, out_data=0x0F, out_carry=0.
- WIDTH=1: single beat sum0=1, sum1=1, carry0=0, carry1=1 -> out_data=0, out_carry=1, out_valid two cycles after the beat.
